mc_main_control: RTL

- Multi-cycle MIPS main control FSM.
- Sits directly upstream of the ALU control block. Consumes the instruction opcode and the ALU zero flag, and produces the 2-bit alu_op consumed by ALU control.
- Also produces all datapath enables and mux selects: PC, memory, IR, register file and ALU sources.
- Adds a memory-ready stall handshake so fetch and data accesses can take more than one cycle.

---
 rtl/mc_main_control_pkg.sv | 40 ++++
 rtl/mc_main_control_if.sv | 32 +++
 rtl/mc_main_control.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mc_main_control_pkg.sv
// rtl/mc_main_control_pkg.sv - shared encodings for the multi-cycle MIPS main control FSM
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  // alu_op is also the input encoding of the downstream ALU control block
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG      = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM      = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

endpackage

// File: rtl/mc_main_control_if.sv
// rtl/mc_main_control_if.sv - control/datapath bundle between main control and the datapath
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       illegal;

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state, illegal
  );

  modport master (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state, illegal
  );
endinterface

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle MIPS main control FSM with memory-ready stalls
// Optional feature: MC_ADDI_EN adds the ADDIEX/ADDIWB path for OP_ADDI.
module mc_main_control
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_main_control_if.slave  bus
);

  state_t r_state;
  state_t w_next;

  logic w_pc_write;
  logic w_pc_write_cond;
  logic w_reg_write;
  logic w_mem_write;
  logic w_ir_write;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
`ifdef MC_ADDI_EN
      S_ADDIEX: w_next = S_ADDIWB;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = ALU_SRC_B_REG;
    bus.alu_op      = ALU_OP_ADD;
    bus.pc_src      = PC_SRC_ALU;
    bus.illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        // IR load and PC increment happen only on the completing cycle of a stalled fetch
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALU_SRC_B_FOUR;
        w_ir_write    = bus.mem_ready;
        w_pc_write    = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = ALU_SRC_B_IMM_SHL2;
        case (bus.opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: bus.illegal = 1'b0;
`ifdef MC_ADDI_EN
          OP_ADDI:                              bus.illegal = 1'b0;
`endif
          default:                              bus.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write    = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        bus.iord    = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_op      = ALU_OP_SUB;
        w_pc_write_cond = 1'b1;
        bus.pc_src      = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        bus.pc_src = PC_SRC_JUMP;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALU_SRC_B_IMM;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
`endif
      default: begin
        w_pc_write = 1'b0;
      end
    endcase
    // Architectural side effects are blocked for the whole reset cycle
    bus.pc_en     = ~reset & (w_pc_write | (w_pc_write_cond & bus.zero));
    bus.reg_write = ~reset & w_reg_write;
    bus.mem_write = ~reset & w_mem_write;
    bus.ir_write  = ~reset & w_ir_write;
  end

  assign bus.state = r_state;

endmodule
